// File: rtl/column_vector_collector_if.sv
// ----------------------------------------------------------------------------
// column_vector_collector_if
//
// Purpose:
//   Bundles the two valid/ready handshakes of the column vector collector.
//   The serial column stream comes in on the in_* signals. The packed row
//   and its sum go out on the out_* signals.
//
// Signals:
//   in_valid    producer -> collector   in_data is valid
//   in_ready    collector -> producer   collector accepts in_data this cycle
//   in_data     producer -> collector   signed column element, DATA_W bits
//   col_index   collector -> producer   slot the next accepted element fills
//   out_valid   collector -> consumer   out_vector/out_sum hold a full row
//   out_ready   consumer -> collector   consumer accepts the row
//   out_vector  collector -> consumer   packed row, slot k at [k*DATA_W +: DATA_W]
//   out_sum     collector -> consumer   signed row sum, DATA_W+IDX_W bits
//
// Modports:
//   master  the environment driving the collector (producer and consumer)
//   slave   the collector itself
// ----------------------------------------------------------------------------
interface column_vector_collector_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_COLS = 3,
    parameter int IDX_W    = 2
);
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_W-1:0]            in_data;
    logic [IDX_W-1:0]             col_index;
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_COLS*DATA_W-1:0]   out_vector;
    logic [DATA_W+IDX_W-1:0]      out_sum;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  col_index,
        input  out_valid,
        input  out_vector,
        input  out_sum
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output col_index,
        output out_valid,
        output out_vector,
        output out_sum
    );
endinterface

// File: rtl/column_vector_collector.sv
// ----------------------------------------------------------------------------
// column_vector_collector
//
// Purpose:
//   Collects a serial stream of per-column elements, NUM_COLS per row, over a
//   valid/ready handshake. Each row is packed into a parallel vector and its
//   signed sum is accumulated as the elements arrive. The finished row is
//   presented over a second valid/ready handshake. While the row is held,
//   accepting the first element of the next row is allowed in the same cycle
//   as the row hand-off, so back-to-back rows flow without a bubble.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous reset, active low
//   clear    synchronous clear, active high; beats any accept on the same edge
//   bus      column_vector_collector_if.slave (both handshakes, col_index)
//
// Parameters:
//   DATA_W    signed element width
//   NUM_COLS  columns per row, 2..4
//   IDX_W     column index width, 2**IDX_W >= NUM_COLS
// ----------------------------------------------------------------------------
module column_vector_collector #(
    parameter int DATA_W   = 16,
    parameter int NUM_COLS = 3,
    parameter int IDX_W    = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear,
    column_vector_collector_if.slave     bus
);

    localparam int SUM_W = DATA_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(NUM_COLS - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   state_reg;
    logic [IDX_W-1:0]         col_index_reg;
    logic                     out_valid_reg;
    logic signed [SUM_W-1:0]  sum_reg;

    logic                     in_ready_int;
    logic                     in_accept;
    logic                     out_accept;
    logic [IDX_W-1:0]         write_slot;
    logic signed [SUM_W-1:0]  in_ext;

    // In HOLD a new element can only enter when the held row leaves in the
    // same cycle, so in_ready follows out_ready there.
    assign in_ready_int = (state_reg == FILL) ? 1'b1 : bus.out_ready;
    assign in_accept    = bus.in_valid && in_ready_int;
    assign out_accept   = out_valid_reg && bus.out_ready;

    // col_index is 0 throughout HOLD, but select slot 0 explicitly so the
    // overlap write does not depend on that invariant.
    assign write_slot   = (state_reg == HOLD) ? '0 : col_index_reg;

    assign in_ext       = {{IDX_W{bus.in_data[DATA_W-1]}}, bus.in_data};

    // ------------------------------------------------------------------------
    // Control FSM, column index, row sum
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= FILL;
            col_index_reg <= '0;
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
        end else if (clear) begin
            state_reg     <= FILL;
            col_index_reg <= '0;
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (in_accept) begin
                        // First column starts a fresh sum, later ones add.
                        if (col_index_reg == '0) begin
                            sum_reg <= in_ext;
                        end else begin
                            sum_reg <= sum_reg + in_ext;
                        end
                        if (col_index_reg == LAST_COL) begin
                            col_index_reg <= '0;
                            state_reg     <= HOLD;
                            out_valid_reg <= 1'b1;
                        end else begin
                            col_index_reg <= col_index_reg + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_accept) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= FILL;
                        // Overlapped accept: the new element is column 0 of
                        // the next row.
                        if (in_accept) begin
                            sum_reg       <= in_ext;
                            col_index_reg <= IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg     <= FILL;
                    col_index_reg <= '0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Row slots: one register per column, written when its index is selected
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_slot
            logic [DATA_W-1:0] slot_reg;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    slot_reg <= '0;
                end else if (clear) begin
                    slot_reg <= '0;
                end else if (in_accept && (write_slot == IDX_W'(gi))) begin
                    slot_reg <= bus.in_data;
                end
            end

            assign bus.out_vector[gi*DATA_W +: DATA_W] = slot_reg;
        end
    endgenerate

    assign bus.in_ready  = in_ready_int;
    assign bus.col_index = col_index_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = sum_reg;

endmodule

// File: tb/tb_column_vector_collector.sv
// ----------------------------------------------------------------------------
// tb_column_vector_collector
//
// Directed steps from the test plan followed by a randomized run. The
// reference model keeps the current row as a queue of elements and derives
// the expected vector and sum from it with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_column_vector_collector;

    localparam int DATA_W   = 16;
    localparam int NUM_COLS = 3;
    localparam int IDX_W    = 2;
    localparam int SUM_W    = DATA_W + IDX_W;
    localparam int VEC_W    = NUM_COLS * DATA_W;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic clear   = 1'b0;

    always #5 clock = ~clock;

    column_vector_collector_if #(
        .DATA_W   (DATA_W),
        .NUM_COLS (NUM_COLS),
        .IDX_W    (IDX_W)
    ) bus ();

    column_vector_collector #(
        .DATA_W   (DATA_W),
        .NUM_COLS (NUM_COLS),
        .IDX_W    (IDX_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int rows_out = 0;

    // Reference model: elements of the row being built (or held), whether a
    // complete row is held, and whether the datapath is known to be all-zero.
    logic signed [DATA_W-1:0] row_q[$];
    bit full   = 1'b0;
    bit zeroed = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic row_expect(output logic [VEC_W-1:0] ev, output logic [SUM_W-1:0] es);
        int s;
        ev = '0;
        s  = 0;
        foreach (row_q[k]) begin
            ev[k*DATA_W +: DATA_W] = row_q[k];
            s += int'(row_q[k]);
        end
        es = SUM_W'(s);
    endtask

    task automatic check_outputs(input bit ordy);
        logic [VEC_W-1:0] ev;
        logic [SUM_W-1:0] es;
        row_expect(ev, es);
        check("in_ready", {63'd0, bus.in_ready}, {63'd0, (!full || ordy)});
        check("col_index", 64'(bus.col_index), full ? 64'd0 : 64'(row_q.size()));
        check("out_valid", {63'd0, bus.out_valid}, {63'd0, full});
        if (full || zeroed) begin
            check("out_vector", 64'(bus.out_vector), 64'(ev));
            check("out_sum", 64'(bus.out_sum), 64'(es));
        end
    endtask

    // One clock cycle: drive at negedge, check just after, update the model
    // with what the rules say happens on the following rising edge.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit ordy, input bit clr);
        bit in_acc;
        bit out_acc;
        logic [VEC_W-1:0] ev;
        logic [SUM_W-1:0] es;
        @(negedge clock);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        clear         = clr;
        #1;
        check_outputs(ordy);
        in_acc  = v && (!full || ordy);
        out_acc = full && ordy;
        @(posedge clock);
        if (clr) begin
            row_q.delete();
            full   = 1'b0;
            zeroed = 1'b1;
            $display("clear: row state discarded");
        end else begin
            if (out_acc) begin
                row_expect(ev, es);
                rows_out++;
                $display("row %0d handed off: {%0d, %0d, %0d} sum %0d", rows_out,
                         row_q[0], row_q[1], row_q[2], $signed(es));
                full = 1'b0;
                row_q.delete();
            end
            if (in_acc) begin
                row_q.push_back(d);
                zeroed = 1'b0;
                if (row_q.size() == NUM_COLS) full = 1'b1;
            end
        end
    endtask

    task automatic async_reset_mid_cycle();
        @(negedge clock);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear         = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("areset out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("areset col_index", 64'(bus.col_index), 64'd0);
        check("areset out_vector", 64'(bus.out_vector), 64'd0);
        check("areset out_sum", 64'(bus.out_sum), 64'd0);
        row_q.delete();
        full   = 1'b0;
        zeroed = 1'b1;
        $display("async reset applied mid-cycle");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        bit rv, rr, rc;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_outputs(1'b0);

        // Basic row: 5, -3, 10 -> sum 12
        step(1, 16'sd5, 1, 0);
        step(1, -16'sd3, 1, 0);
        step(1, 16'sd10, 1, 0);
        step(0, 16'd0, 1, 0);
        step(0, 16'd0, 1, 0);

        // Backpressure: 100, 200, 300 held for 4 cycles with 7 waiting
        step(1, 16'sd100, 0, 0);
        step(1, 16'sd200, 0, 0);
        step(1, 16'sd300, 0, 0);
        repeat (4) step(1, 16'sd7, 0, 0);
        step(1, 16'sd7, 1, 0);
        step(0, 16'd0, 1, 0);
        step(1, 16'sd1, 1, 0);
        step(1, 16'sd1, 1, 0);
        step(0, 16'd0, 1, 0);

        // Back-to-back rows with no bubbles
        step(1, 16'sd1, 1, 0);
        step(1, 16'sd2, 1, 0);
        step(1, 16'sd3, 1, 0);
        repeat (3) step(1, 16'h8000, 1, 0);
        step(0, 16'd0, 1, 0);
        step(0, 16'd0, 1, 0);

        // Input gaps: 4, idle x2, 6, idle, 8
        step(1, 16'sd4, 1, 0);
        step(0, 16'd0, 1, 0);
        step(0, 16'd0, 1, 0);
        step(1, 16'sd6, 1, 0);
        step(0, 16'd0, 1, 0);
        step(1, 16'sd8, 1, 0);
        step(0, 16'd0, 0, 0);
        step(0, 16'd0, 1, 0);

        // Clear after two elements, with in_valid high on the clear edge
        step(1, 16'sd11, 1, 0);
        step(1, 16'sd12, 1, 0);
        step(1, 16'sd13, 1, 1);
        step(0, 16'd0, 1, 0);

        // Clear while holding a full row, with an overlapped accept offered
        step(1, 16'sd21, 0, 0);
        step(1, 16'sd22, 0, 0);
        step(1, 16'sd23, 0, 0);
        step(1, 16'sd24, 1, 1);
        step(0, 16'd0, 1, 0);

        // Async reset while in HOLD
        step(1, 16'sd31, 0, 0);
        step(1, 16'sd32, 0, 0);
        step(1, 16'sd33, 0, 0);
        step(0, 16'd0, 0, 0);
        async_reset_mid_cycle();
        step(1, 16'sd41, 1, 0);
        step(0, 16'd0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 99) < 70);
            rr = ($urandom_range(0, 99) < 60);
            rc = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 7))
                0:       rd = 16'h8000;
                1:       rd = 16'h7FFF;
                default: rd = 16'($urandom);
            endcase
            step(rv, rd, rr, rc);
        end
        step(0, 16'd0, 1, 0);
        step(0, 16'd0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
